// File: rtl/ctrl_opcode_issuer_if.sv
// Request/opcode handshake bundle for ctrl_opcode_issuer.
// Define CTRL_ISSUER_PARITY_EN to widen op_code by one even-parity MSB.
interface ctrl_opcode_issuer_if #(
    parameter int REQ_W = 26,
    parameter int IDX_W = 5,
    parameter int TAG_W = 2
);
    localparam int OP_W = IDX_W + TAG_W;
`ifdef CTRL_ISSUER_PARITY_EN
    localparam int CODE_W = OP_W + 1;
`else
    localparam int CODE_W = OP_W;
`endif

    // Both channels: a beat transfers on a rising edge where valid & ready are high;
    // the sender holds valid and payload stable until that edge.
    logic              req_valid;
    logic              req_ready;
    logic [REQ_W-1:0]  req_ctrl;
    logic              op_valid;
    logic              op_ready;
    logic [CODE_W-1:0] op_code;

    modport master (
        output req_valid, req_ctrl, op_ready,
        input  req_ready, op_valid, op_code
    );

    modport slave (
        input  req_valid, req_ctrl, op_ready,
        output req_ready, op_valid, op_code
    );
endinterface

// File: rtl/ctrl_opcode_issuer.sv
// Issues one {tag, index} opcode per set request bit, lowest index first.
// Define CTRL_ISSUER_PARITY_EN to append an even-parity MSB to op_code.
module ctrl_opcode_issuer #(
    parameter int REQ_W   = 26,
    parameter int IDX_W   = 5,
    parameter int TAG_W   = 2,
    parameter int RSV_BIT = 23
) (
    input  logic                clock,
    input  logic                reset,
    ctrl_opcode_issuer_if.slave bus,
    output logic                busy,
    output logic                err_empty,
    output logic                state_dbg
);
    localparam int OP_W = IDX_W + TAG_W;
`ifdef CTRL_ISSUER_PARITY_EN
    localparam int CODE_W = OP_W + 1;
`else
    localparam int CODE_W = OP_W;
`endif
    localparam logic [REQ_W-1:0] RSV_MASK = REQ_W'(1) << RSV_BIT;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [REQ_W-1:0]  pending_q, pending_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              err_q, err_d;
    logic [REQ_W-1:0]  masked;
    logic [IDX_W-1:0]  cur_idx, nxt_idx;
    logic [OP_W-1:0]   nxt_op;

    function automatic logic [IDX_W-1:0] lowest(input logic [REQ_W-1:0] v);
        lowest = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    assign cur_idx = code_q[IDX_W-1:0];

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tag_d     = tag_q;
        err_d     = 1'b0;
        masked    = bus.req_ctrl & ~RSV_MASK;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    pending_d = masked;
                    if (masked == '0) err_d   = 1'b1;
                    else              state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.op_ready) begin
                    pending_d = pending_q & ~(REQ_W'(1) << cur_idx);
                    tag_d     = tag_q + TAG_W'(1);
                    if (pending_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The next opcode is precomputed so op_code comes straight from a flop.
        nxt_idx = lowest(pending_d);
        nxt_op  = {tag_d, nxt_idx};
`ifdef CTRL_ISSUER_PARITY_EN
        code_d = {^nxt_op, nxt_op};
`else
        code_d = nxt_op;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            tag_q     <= '0;
            code_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tag_q     <= tag_d;
            code_q    <= code_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.op_valid  = (state_q == ISSUE);
    assign bus.op_code   = code_q;
    assign busy          = |pending_q;
    assign err_empty     = err_q;
    assign state_dbg     = state_q;
endmodule
